// File: rtl/bcd_counter_bank.sv
// bcd_counter_bank: N-digit BCD up/down counter bank.
// Raw switch/button levels are synchronised, rising edges on inc/dec latch
// per-digit pending flags, and one flag (or a clear/fill) is served on each
// cycle with ce=1. Increments and decrements ripple carry/borrow across all
// digits within one cycle. Carry or borrow out of the top digit either
// saturates or wraps, depending on WRAP.
module bcd_counter_bank #(
    parameter int DIGITS      = 4,
    parameter int WRAP        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [DIGITS-1:0]     inc,
    input  logic [DIGITS-1:0]     dec,
    input  logic                  btn_clear,
    input  logic                  btn_fill,
    output logic [4*DIGITS-1:0]   value,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  busy
);

    localparam int RAW_W = 2 * DIGITS + 2;
    localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLEAR,
        OP_FILL,
        OP_CANCEL,
        OP_INC,
        OP_DEC
    } op_t;

    // All raw inputs share one synchroniser chain: {fill, clear, dec, inc}.
    logic [RAW_W-1:0]    raw;
    logic [RAW_W-1:0]    sync_q [SYNC_STAGES];
    logic [RAW_W-1:0]    synced;
    logic [2*DIGITS-1:0] prev;
    logic [2*DIGITS-1:0] events;
    logic [DIGITS-1:0]   inc_ev;
    logic [DIGITS-1:0]   dec_ev;
    logic                clear_s;
    logic                fill_s;

    logic [DIGITS-1:0]   inc_p;
    logic [DIGITS-1:0]   dec_p;
    logic [DIGITS-1:0]   inc_clr;
    logic [DIGITS-1:0]   dec_clr;
    logic [DIGITS-1:0]   sel_oh;
    op_t                 op;

    logic [4*DIGITS-1:0] inc_val;
    logic [4*DIGITS-1:0] dec_val;
    logic                carry_out;
    logic                borrow_out;

    assign raw     = {btn_fill, btn_clear, dec, inc};
    assign synced  = sync_q[SYNC_STAGES-1];
    assign clear_s = synced[2*DIGITS];
    assign fill_s  = synced[2*DIGITS+1];
    assign events  = synced[2*DIGITS-1:0] & ~prev;
    assign inc_ev  = events[DIGITS-1:0];
    assign dec_ev  = events[2*DIGITS-1:DIGITS];
    assign busy    = |{inc_p, dec_p};

    // Synchroniser chain and edge history; reset to 1 so an input that is
    // already high when reset releases never looks like a fresh rising edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
            prev <= '1;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= synced[2*DIGITS-1:0];
        end
    end

    // Service arbitration: clear, fill, same-digit cancel, then the lowest
    // set flag with inc ahead of dec at each digit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves a signal unassigned (no latch).
        op      = OP_NONE;
        inc_clr = '0;
        dec_clr = '0;
        sel_oh  = '0;
        if (ce) begin
            if (clear_s) begin
                op = OP_CLEAR;
            end else if (fill_s) begin
                op = OP_FILL;
            end else if (|(inc_p & dec_p)) begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (op == OP_NONE && inc_p[k] && dec_p[k]) begin
                        op         = OP_CANCEL;
                        inc_clr[k] = 1'b1;
                        dec_clr[k] = 1'b1;
                    end
                end
            end else begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (op == OP_NONE) begin
                        if (inc_p[k]) begin
                            op         = OP_INC;
                            inc_clr[k] = 1'b1;
                            sel_oh[k]  = 1'b1;
                        end else if (dec_p[k]) begin
                            op         = OP_DEC;
                            dec_clr[k] = 1'b1;
                            sel_oh[k]  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Ripple +1 and -1 from the selected digit upward; digits below it stay.
    always_comb begin
        inc_val    = value;
        dec_val    = value;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_oh[i] || carry_out) begin
                if (value[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                    carry_out         = 1'b1;
                end else begin
                    inc_val[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry_out         = 1'b0;
                end
            end
            if (sel_oh[i] || borrow_out) begin
                if (value[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                    borrow_out        = 1'b1;
                end else begin
                    dec_val[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    borrow_out        = 1'b0;
                end
            end
        end
    end

    // Pending flags, value register and the one-cycle range-end pulses.
    // A new event wins over a same-cycle service clear of its flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            value     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inc_p     <= '0;
            dec_p     <= '0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (op == OP_CLEAR || op == OP_FILL) begin
                inc_p <= '0;
                dec_p <= '0;
            end else begin
                inc_p <= (inc_p & ~inc_clr) | inc_ev;
                dec_p <= (dec_p & ~dec_clr) | dec_ev;
            end
            case (op)
                OP_CLEAR: value <= '0;
                OP_FILL:  value <= NINES;
                OP_INC: begin
                    value    <= (carry_out && WRAP == 0) ? NINES : inc_val;
                    overflow <= carry_out;
                end
                OP_DEC: begin
                    value     <= (borrow_out && WRAP == 0) ? '0 : dec_val;
                    underflow <= borrow_out;
                end
                default: ;
            endcase
        end
    end

endmodule
